// File: rtl/ram_dq_clr.sv
// ram_dq_clr: single-clock synchronous RAM with a registered read port,
// a one-cycle read valid strobe and a built-in clear engine that fills
// every word with CLEAR_VALUE after reset or on a clear request.
//
// Optional feature macro: RAM_BYPASS_EN
//   defined   -> same-cycle write+read returns the new write data (write-through)
//   undefined -> same-cycle write+read returns the old stored word (read-first)
//
// Handshake: a read is accepted on an edge where re=1, clear=0 and the
// engine is not busy; q and q_valid then update on that same edge and
// q_valid is high for exactly the following cycle. Accesses presented while
// busy=1 or clear=1 are dropped, never queued.
module ram_dq_clr #(
   parameter int               WIDTH       = 16,
   parameter int               AW          = 6,
   parameter logic [WIDTH-1:0] CLEAR_VALUE = {WIDTH{1'b0}}
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             we,
   input  logic             re,
   input  logic [AW-1:0]    address,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   output logic             busy
);

   localparam int DEPTH = 1 << AW;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   state_t           state;
   logic [AW-1:0]    count;
   logic [WIDTH-1:0] mem [DEPTH];

   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic [WIDTH-1:0] rd_word;

   // Write port select: clear engine owns the array while clearing,
   // a clear request blocks all writes, otherwise the user port writes.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = address;
      wr_data = data;
      if (!clear) begin
         if (state == CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = count;
            wr_data = CLEAR_VALUE;
         end else if (we) begin
            wr_en = 1'b1;
         end
      end
   end

   // Read word selection; with forwarding, a same-cycle write wins
   // (address is shared, so a simultaneous write always collides).
   always_comb begin
`ifdef RAM_BYPASS_EN
      rd_word = we ? data : mem[address];
`else
      rd_word = mem[address];
`endif
   end

   // Memory array: no reset, contents defined only by the clear engine and writes.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Control FSM, clear counter and registered read outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= CLEAR;
         count   <= '0;
         q       <= '0;
         q_valid <= 1'b0;
         busy    <= 1'b1;
      end else if (clear) begin
         state   <= CLEAR;
         count   <= '0;
         q_valid <= 1'b0;
         busy    <= 1'b1;
      end else begin
         case (state)
            CLEAR: begin
               q_valid <= 1'b0;
               count   <= count + 1'b1;
               if (&count) begin
                  state <= READY;
                  busy  <= 1'b0;
               end
            end
            READY: begin
               if (re) begin
                  q       <= rd_word;
                  q_valid <= 1'b1;
               end else begin
                  q_valid <= 1'b0;
               end
            end
            default: begin
               state   <= CLEAR;
               count   <= '0;
               q_valid <= 1'b0;
               busy    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_dq_clr.sv
// tb_ram_dq_clr: directed bench for ram_dq_clr (WIDTH=16, AW=6, CLEAR_VALUE=0).
// Reads push their expected word into exp_q; a monitor pops and compares
// whenever q_valid is seen.
module tb_ram_dq_clr;

   localparam int WIDTH = 16;
   localparam int AW    = 6;

   logic             clk;
   logic             rst;
   logic             clear;
   logic             we;
   logic             re;
   logic [AW-1:0]    address;
   logic [WIDTH-1:0] data;
   logic [WIDTH-1:0] q;
   logic             q_valid;
   logic             busy;

   int total = 0;
   int bad   = 0;
   logic [WIDTH-1:0] exp_q[$];

   ram_dq_clr #(
      .WIDTH       (WIDTH),
      .AW          (AW),
      .CLEAR_VALUE (16'h0000)
   ) dut (
      .clock   (clk),
      .reset   (rst),
      .clear   (clear),
      .we      (we),
      .re      (re),
      .address (address),
      .data    (data),
      .q       (q),
      .q_valid (q_valid),
      .busy    (busy)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // ---------------- checks ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(posedge clk) begin
      #1;
      if (q_valid === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_valid: q=%h with no read outstanding", q);
         end else begin
            logic [WIDTH-1:0] e;
            e = exp_q.pop_front();
            if (q !== e) begin
               bad++;
               $display("FAIL read_data: got %h expected %h", q, e);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic w, input logic r, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
      @(negedge clk);
      we      = w;
      re      = r;
      address = a;
      data    = d;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
      drive(1'b1, 1'b0, a, d);
   endtask

   task automatic do_read(input logic [AW-1:0] a, input logic [WIDTH-1:0] e);
      drive(1'b0, 1'b1, a, '0);
      exp_q.push_back(e);
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, '0, '0);
   endtask

   // Counts edges until busy is seen low, bounded.
   task automatic wait_ready(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (busy && n < 200);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      logic [WIDTH-1:0] coll_exp;
      rst     = 1'b0;
      clear   = 1'b0;
      we      = 1'b0;
      re      = 1'b0;
      address = '0;
      data    = '0;
      #1 rst = 1'b1;
      #2;
      check("reset_q", 32'(q), 32'h0);
      check("reset_q_valid", 32'(q_valid), 32'h0);
      check("reset_busy", 32'(busy), 32'h1);

      // Reset release and clear duration
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      wait_ready(n);
      check("reset_clear_cycles", 32'(n), 32'd64);

      // Every word reads back CLEAR_VALUE
      for (int i = 0; i < 64; i++) do_read(i[AW-1:0], 16'h0000);
      idle();

      // Write then read, then q hold
      do_write(6'd5, 16'hA5C3);
      do_write(6'd63, 16'h1234);
      do_read(6'd5, 16'hA5C3);
      do_read(6'd63, 16'h1234);
      idle();
      @(negedge clk);
      check("hold_q", 32'(q), 32'h1234);
      check("hold_q_valid", 32'(q_valid), 32'h0);

      // Same-address write+read collision
`ifdef RAM_BYPASS_EN
      coll_exp = 16'hBEEF;
`else
      coll_exp = 16'h00FF;
`endif
      do_write(6'd9, 16'h00FF);
      drive(1'b1, 1'b1, 6'd9, 16'hBEEF);
      exp_q.push_back(coll_exp);
      do_read(6'd9, 16'hBEEF);
      idle();

      // Clear request mid-traffic, then again mid-clear
      do_write(6'd20, 16'h7777);
      do_read(6'd20, 16'h7777);
      idle();
      @(negedge clk);
      clear = 1'b1;
      we = 1'b1; re = 1'b1; address = 6'd20; data = 16'h1111;
      @(posedge clk);
      #1;
      check("clear_busy_rise", 32'(busy), 32'h1);
      for (int i = 1; i < 30; i++) begin
         @(negedge clk);
         clear = 1'b0;
         we = 1'b1; re = 1'b1; address = i[AW-1:0]; data = 16'hDEAD;
      end
      @(negedge clk);
      clear = 1'b1;
      @(posedge clk);
      #1;
      check("reclear_busy", 32'(busy), 32'h1);
      n = 0;
      do begin
         @(negedge clk);
         clear   = 1'b0;
         we      = 1'b1;
         re      = 1'b1;
         address = n[AW-1:0];
         data    = 16'hCAFE;
         @(posedge clk);
         #1;
         n++;
      end while (busy && n < 200);
      check("reclear_cycles", 32'(n), 32'd64);
      idle();
      @(negedge clk);
      check("clear_hold_q", 32'(q), 32'h7777);
      check("clear_hold_q_valid", 32'(q_valid), 32'h0);
      do_read(6'd20, 16'h0000);
      do_read(6'd1, 16'h0000);
      do_read(6'd29, 16'h0000);
      do_read(6'd63, 16'h0000);
      idle();

      // Async reset while a read result is presented
      do_write(6'd9, 16'hBEEF);
      do_read(6'd9, 16'hBEEF);
      @(posedge clk);
      #2;
      we = 1'b0;
      re = 1'b0;
      check("pre_reset_q", 32'(q), 32'hBEEF);
      check("pre_reset_q_valid", 32'(q_valid), 32'h1);
      #1 rst = 1'b1;
      #1;
      check("async_reset_q", 32'(q), 32'h0);
      check("async_reset_q_valid", 32'(q_valid), 32'h0);
      check("async_reset_busy", 32'(busy), 32'h1);
      @(negedge clk);
      rst = 1'b0;
      wait_ready(n);
      check("rereset_clear_cycles", 32'(n), 32'd64);
      do_read(6'd9, 16'h0000);
      do_read(6'd5, 16'h0000);
      do_read(6'd0, 16'h0000);
      idle();

      // Final report
      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
